// File: rtl/lv_owt_pkg.sv
// Shared types and constants for the OWT request scheduler.
package lv_owt_pkg;

  localparam int unsigned REG_DW = 8;
  localparam int unsigned REG_AW = 7;

  // Register polled by a watchdog heartbeat transaction
  localparam logic [REG_AW-1:0] WDG_ADDR_DEF = 7'h1e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StIssue  = 3'd1,
    StWaitTx = 3'd2,
    StWaitRx = 3'd3,
    StDone   = 3'd4,
    StErr    = 3'd5
  } owt_sched_st_e;

  typedef enum logic {
    ReqSpi = 1'b0,
    ReqWdg = 1'b1
  } owt_req_src_e;

  typedef struct packed {
    logic              wr;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] wdata;
  } owt_req_t;

endpackage

// File: rtl/lv_owt_tmo_cnt.sv
// Response timeout counter: clear, count while enabled, flag the last cycle.
// Saturates at RX_TMO_CYC-1 instead of wrapping.
module lv_owt_tmo_cnt #(
  parameter int unsigned RX_TMO_CYC = 4096
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = (RX_TMO_CYC > 1) ? $clog2(RX_TMO_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(RX_TMO_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles, holding at the terminal value
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/lv_owt_req_sched.sv
// OWT transaction scheduler: buffers one SPI request, arbitrates it against
// watchdog heartbeats, and sequences issue / transmit / response on the link.
// Optional macro LV_OWT_RETRY_EN enables up to MAX_RETRY retries per request.
module lv_owt_req_sched
  import lv_owt_pkg::*;
#(
  parameter logic [REG_AW-1:0] WDG_ADDR   = WDG_ADDR_DEF,
  parameter int unsigned       RX_TMO_CYC = 4096
`ifdef LV_OWT_RETRY_EN
  ,
  parameter int unsigned       MAX_RETRY  = 2
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_owt_wen,
  input  logic              i_spi_owt_ren,
  input  logic [REG_DW-1:0] i_spi_owt_wdata,
  input  logic [REG_AW-1:0] i_spi_owt_addr,
  output logic [REG_DW-1:0] o_spi_owt_rdata,
  output logic              o_spi_owt_done,
  output logic              o_spi_owt_ovf,
  input  logic              i_wdg_owt_req,
  output logic              o_owt_wdg_ack,
  output logic              o_owt_req,
  output logic [REG_AW:0]   o_owt_cmd,
  output logic [REG_DW-1:0] o_owt_wdata,
  input  logic              i_owt_ack,
  input  logic              i_owt_tx_done,
  input  logic              i_owt_rx_vld,
  input  logic [REG_DW-1:0] i_owt_rx_data,
  input  logic              i_owt_rx_crc_err,
  output logic              o_owt_err,
  output logic              o_owt_err_src
);

  owt_sched_st_e r_state, w_state_nxt;
  owt_req_t      r_spi_buf;
  owt_req_src_e  r_src, r_last_gnt;
  logic          r_spi_pend, r_spi_ovf, r_wdg_req;
  logic [REG_AW:0]   r_cmd;
  logic [REG_DW-1:0] r_wdata, r_rdata;

  logic w_spi_pulse, w_gnt_spi, w_gnt_wdg, w_finish, w_wdg_ack;
  logic w_rx_ok, w_fail, w_retry_ok, w_tmo_clr, w_tmo_en, w_tmo_exp;

  assign w_spi_pulse = i_spi_owt_wen | i_spi_owt_ren;
  assign w_finish    = (r_state == StDone) || (r_state == StErr);
  assign w_wdg_ack   = w_finish && (r_src == ReqWdg);
  assign w_rx_ok     = (r_state == StWaitRx) && i_owt_rx_vld && !i_owt_rx_crc_err;
  assign w_fail      = (r_state == StWaitRx) && !w_rx_ok &&
                       ((i_owt_rx_vld && i_owt_rx_crc_err) || w_tmo_exp);
  assign w_tmo_clr   = (r_state == StWaitTx) && i_owt_tx_done && !r_cmd[REG_AW];
  assign w_tmo_en    = (r_state == StWaitRx);

  // Round-robin grant: on a tie the requester not served last wins
  always_comb begin
    w_gnt_spi = (r_state == StIdle) && r_spi_pend && (!r_wdg_req || (r_last_gnt == ReqWdg));
    w_gnt_wdg = (r_state == StIdle) && r_wdg_req && !w_gnt_spi;
  end

  // One-deep SPI buffer; a pulse landing on the grant cycle refills it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_spi_pend <= 1'b0;
      r_spi_ovf  <= 1'b0;
      r_spi_buf  <= '0;
    end else begin
      r_spi_ovf <= w_spi_pulse && r_spi_pend && !w_gnt_spi;
      if (w_spi_pulse && (!r_spi_pend || w_gnt_spi)) begin
        r_spi_pend      <= 1'b1;
        r_spi_buf.wr    <= i_spi_owt_wen;
        r_spi_buf.addr  <= i_spi_owt_addr;
        r_spi_buf.wdata <= i_spi_owt_wen ? i_spi_owt_wdata : '0;
      end else if (w_gnt_spi) begin
        r_spi_pend <= 1'b0;
      end
    end
  end

  // Watchdog level registered so it lines up with the SPI buffer latency;
  // masked on ack so a level still high in the ack cycle does not re-grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdg_req <= 1'b0;
    end else begin
      r_wdg_req <= i_wdg_owt_req && !w_wdg_ack;
    end
  end

`ifdef LV_OWT_RETRY_EN
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] r_retry_cnt;

  assign w_retry_ok = (r_retry_cnt < RW'(MAX_RETRY));

  // Retry counter, cleared when a request completes either way
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_retry_cnt <= '0;
    end else if (w_finish) begin
      r_retry_cnt <= '0;
    end else if (w_fail && w_retry_ok) begin
      r_retry_cnt <= r_retry_cnt + RW'(1);
    end
  end
`else
  assign w_retry_ok = 1'b0;
`endif

  // Next-state decode for the transaction sequencer
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_gnt_spi || w_gnt_wdg) w_state_nxt = StIssue;
      StIssue:  if (i_owt_ack) w_state_nxt = StWaitTx;
      StWaitTx: if (i_owt_tx_done) w_state_nxt = r_cmd[REG_AW] ? StDone : StWaitRx;
      StWaitRx: begin
        if (w_rx_ok) begin
          w_state_nxt = StDone;
        end else if (w_fail) begin
          w_state_nxt = w_retry_ok ? StIssue : StErr;
        end
      end
      StDone:   w_state_nxt = StIdle;
      StErr:    w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // State, latched command on grant, and SPI read data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cmd      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_src      <= ReqSpi;
      r_last_gnt <= ReqWdg;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_spi) begin
        r_cmd      <= {r_spi_buf.wr, r_spi_buf.addr};
        r_wdata    <= r_spi_buf.wdata;
        r_src      <= ReqSpi;
        r_last_gnt <= ReqSpi;
      end else if (w_gnt_wdg) begin
        r_cmd      <= {1'b0, WDG_ADDR};
        r_wdata    <= '0;
        r_src      <= ReqWdg;
        r_last_gnt <= ReqWdg;
      end
      if (w_rx_ok && (r_src == ReqSpi)) begin
        r_rdata <= i_owt_rx_data;
      end
    end
  end

  lv_owt_tmo_cnt #(
    .RX_TMO_CYC (RX_TMO_CYC)
  ) u_tmo_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expire (w_tmo_exp)
  );

  assign o_owt_req       = (r_state == StIssue);
  assign o_owt_cmd       = r_cmd;
  assign o_owt_wdata     = r_wdata;
  assign o_spi_owt_rdata = r_rdata;
  assign o_spi_owt_ovf   = r_spi_ovf;
  assign o_spi_owt_done  = w_finish && (r_src == ReqSpi);
  assign o_owt_wdg_ack   = w_wdg_ack;
  assign o_owt_err       = (r_state == StErr);
  assign o_owt_err_src   = (r_state == StErr) && (r_src == ReqWdg);

endmodule

// File: tb/tb_lv_owt_req_sched.sv
// Directed + randomized bench for lv_owt_req_sched (RX_TMO_CYC = 16).
module tb_lv_owt_req_sched;

  localparam int unsigned TMO = 16;
`ifdef LV_OWT_RETRY_EN
  localparam int unsigned ATTEMPTS = 3;
`else
  localparam int unsigned ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_wen = 1'b0, spi_ren = 1'b0;
  logic [7:0] spi_wdata = '0;
  logic [6:0] spi_addr = '0;
  logic [7:0] spi_rdata;
  logic       spi_done, spi_ovf;
  logic       wdg_req = 1'b0, wdg_ack;
  logic       owt_req;
  logic [7:0] owt_cmd, owt_wdata;
  logic       owt_ack = 1'b0, owt_tx_done = 1'b0, owt_rx_vld = 1'b0, owt_crc = 1'b0;
  logic [7:0] owt_rx_data = '0;
  logic       owt_err, owt_err_src;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_rdata = '0;  // model: data of last clean SPI read

  int c_done = 0, c_wack = 0, c_err = 0, c_ovf = 0, c_issue = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  lv_owt_req_sched #(
    .RX_TMO_CYC (TMO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_spi_owt_wen    (spi_wen),
    .i_spi_owt_ren    (spi_ren),
    .i_spi_owt_wdata  (spi_wdata),
    .i_spi_owt_addr   (spi_addr),
    .o_spi_owt_rdata  (spi_rdata),
    .o_spi_owt_done   (spi_done),
    .o_spi_owt_ovf    (spi_ovf),
    .i_wdg_owt_req    (wdg_req),
    .o_owt_wdg_ack    (wdg_ack),
    .o_owt_req        (owt_req),
    .o_owt_cmd        (owt_cmd),
    .o_owt_wdata      (owt_wdata),
    .i_owt_ack        (owt_ack),
    .i_owt_tx_done    (owt_tx_done),
    .i_owt_rx_vld     (owt_rx_vld),
    .i_owt_rx_data    (owt_rx_data),
    .i_owt_rx_crc_err (owt_crc),
    .o_owt_err        (owt_err),
    .o_owt_err_src    (owt_err_src)
  );

  // Pulse counters, independent of the step-by-step checks
  always @(posedge clk) begin
    if (spi_done) c_done <= c_done + 1;
    if (wdg_ack)  c_wack <= c_wack + 1;
    if (owt_err)  c_err  <= c_err + 1;
    if (spi_ovf)  c_ovf  <= c_ovf + 1;
    if (owt_req && !req_prev) c_issue <= c_issue + 1;
    req_prev <= owt_req;
  end

  function automatic logic [31:0] all_outs();
    return {2'b00, spi_rdata, spi_done, spi_ovf, wdg_ack, owt_req, owt_cmd, owt_wdata,
            owt_err, owt_err_src};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 32'h0);
    rst = 1'b0;
    m_rdata = '0;
    tick();
  endtask

  task automatic spi_pulse(input bit wr, input bit rd, input logic [6:0] a, input logic [7:0] d);
    spi_wen = wr;
    spi_ren = rd;
    spi_addr = a;
    spi_wdata = d;
    tick();
    spi_wen = 1'b0;
    spi_ren = 1'b0;
  endtask

  task automatic wait_issue(input logic [7:0] exp_cmd, input logic [7:0] exp_wd, input bit chk_wd);
    int n = 0;
    while (!owt_req && n < 40) begin
      tick();
      n++;
    end
    chk("issue_seen", {31'd0, owt_req}, 32'd1);
    chk("issue_cmd", {24'd0, owt_cmd}, {24'd0, exp_cmd});
    if (chk_wd) chk("issue_wdata", {24'd0, owt_wdata}, {24'd0, exp_wd});
  endtask

  task automatic link_tx();
    owt_ack = 1'b1;
    tick();
    owt_ack = 1'b0;
    chk("req_drop_after_ack", {31'd0, owt_req}, 32'd0);
    repeat ($urandom_range(0, 2)) tick();
    owt_tx_done = 1'b1;
    tick();
    owt_tx_done = 1'b0;
  endtask

  task automatic finish_ok(input bit is_wdg, input bit wr, input logic [7:0] rx);
    link_tx();
    if (!wr) begin
      repeat ($urandom_range(0, 6)) tick();
      owt_rx_vld = 1'b1;
      owt_rx_data = rx;
      tick();
      owt_rx_vld = 1'b0;
      if (!is_wdg) m_rdata = rx;
    end
    chk("done_pulse", {30'd0, spi_done, wdg_ack}, is_wdg ? 32'd1 : 32'd2);
    chk("no_err", {31'd0, owt_err}, 32'd0);
    chk("rdata", {24'd0, spi_rdata}, {24'd0, m_rdata});
    if (is_wdg) wdg_req = 1'b0;
    tick();
    chk("pulse_one_cycle", {30'd0, spi_done, wdg_ack}, 32'd0);
  endtask

  initial begin : main
    logic [6:0] a;
    logic [7:0] d, rx;
    int base_done, base_ovf, base_err, base_issue, early, kind;

    do_reset();

    // SPI write 0x05/0xA5: request timing N+1 / N+2, no WAIT_RX
    spi_pulse(1'b1, 1'b0, 7'h05, 8'hA5);
    chk("req_at_n1", {31'd0, owt_req}, 32'd0);
    tick();
    chk("req_at_n2", {31'd0, owt_req}, 32'd1);
    wait_issue(8'h85, 8'hA5, 1'b1);
    finish_ok(1'b0, 1'b1, 8'h00);

    // SPI read 0x10 returning 0x3C
    spi_pulse(1'b0, 1'b1, 7'h10, 8'h00);
    wait_issue(8'h10, 8'h00, 1'b0);
    finish_ok(1'b0, 1'b0, 8'h3C);

    // Tie after reset: SPI first, then watchdog
    do_reset();
    wdg_req = 1'b1;
    spi_pulse(1'b0, 1'b1, 7'h33, 8'h00);
    wait_issue(8'h33, 8'h00, 1'b0);
    finish_ok(1'b0, 1'b0, 8'($urandom));
    wait_issue(8'h1E, 8'h00, 1'b0);
    finish_ok(1'b1, 1'b0, 8'($urandom));

    // SPI served last, then a tie: watchdog first
    d = 8'($urandom);
    spi_pulse(1'b1, 1'b0, 7'h21, d);
    wait_issue(8'hA1, d, 1'b1);
    finish_ok(1'b0, 1'b1, 8'h00);
    wdg_req = 1'b1;
    d = 8'($urandom);
    spi_pulse(1'b1, 1'b0, 7'h22, d);
    wait_issue(8'h1E, 8'h00, 1'b0);
    finish_ok(1'b1, 1'b0, 8'($urandom));
    wait_issue(8'hA2, d, 1'b1);
    finish_ok(1'b0, 1'b1, 8'h00);

    // Overflow: one buffered pulse, one dropped while busy
    base_done = c_done;
    base_ovf = c_ovf;
    d = 8'($urandom);
    spi_pulse(1'b1, 1'b0, 7'h40, d);
    wait_issue(8'hC0, d, 1'b1);
    spi_pulse(1'b0, 1'b1, 7'h41, 8'h00);
    spi_pulse(1'b1, 1'b0, 7'h42, 8'h77);
    chk("ovf_pulse", {31'd0, spi_ovf}, 32'd1);
    finish_ok(1'b0, 1'b1, 8'h00);
    wait_issue(8'h41, 8'h00, 1'b0);
    finish_ok(1'b0, 1'b0, 8'($urandom));
    repeat (5) tick();
    chk("ovf_no_third_req", {31'd0, owt_req}, 32'd0);
    chk("ovf_done_count", c_done - base_done, 32'd2);
    chk("ovf_count", c_ovf - base_ovf, 32'd1);

    // Randomized SPI traffic; simultaneous wen+ren must act as a write
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      a = 7'($urandom);
      d = 8'($urandom);
      rx = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      spi_pulse(kind != 1, kind != 0, a, d);
      wait_issue({kind != 1, a}, d, kind != 1);
      finish_ok(1'b0, kind != 1, rx);
    end

    // Watchdog timeout with no response
    base_err = c_err;
    base_issue = c_issue;
    wdg_req = 1'b1;
    wait_issue(8'h1E, 8'h00, 1'b0);
    for (int att = 0; att < ATTEMPTS; att++) begin
      link_tx();
      early = 0;
      for (int k = 0; k < TMO - 1; k++) begin
        tick();
        if (owt_req || owt_err) early++;
      end
      chk("tmo_not_early", early, 32'd0);
      tick();
      if (att < ATTEMPTS - 1) begin
        chk("tmo_reissue", {23'd0, owt_req, owt_cmd}, {23'd0, 1'b1, 8'h1E});
      end else begin
        chk("tmo_err_src_ack", {29'd0, owt_err, owt_err_src, wdg_ack, owt_req}, 32'hE);
      end
    end
    wdg_req = 1'b0;
    tick();
    chk("tmo_err_one_cycle", {31'd0, owt_err}, 32'd0);
    chk("tmo_attempts", c_issue - base_issue, ATTEMPTS);
    chk("tmo_err_count", c_err - base_err, 32'd1);

    // CRC error on first response
    a = 7'($urandom);
    spi_pulse(1'b0, 1'b1, a, 8'h00);
    wait_issue({1'b0, a}, 8'h00, 1'b0);
    link_tx();
    owt_rx_vld = 1'b1;
    owt_crc = 1'b1;
    owt_rx_data = 8'($urandom);
    tick();
    owt_rx_vld = 1'b0;
    owt_crc = 1'b0;
`ifdef LV_OWT_RETRY_EN
    chk("crc_retry", {29'd0, owt_req, owt_err, spi_done}, 32'd4);
    rx = 8'($urandom);
    finish_ok(1'b0, 1'b0, rx);
`else
    chk("crc_err", {28'd0, owt_err, owt_err_src, spi_done, owt_req}, 32'hA);
    chk("crc_rdata_kept", {24'd0, spi_rdata}, {24'd0, m_rdata});
    tick();
`endif

    // Reset while waiting for a response
    spi_pulse(1'b0, 1'b1, 7'h2A, 8'h00);
    wait_issue(8'h2A, 8'h00, 1'b0);
    link_tx();
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", all_outs(), 32'h0);
    tick();
    rst = 1'b0;
    m_rdata = '0;
    base_done = c_done;
    base_err = c_err;
    owt_rx_vld = 1'b1;
    owt_rx_data = 8'h5A;
    tick();
    owt_rx_vld = 1'b0;
    repeat (10) tick();
    chk("rst_no_done", (c_done - base_done) + (c_err - base_err), 32'd0);
    chk("rst_outputs_idle", all_outs(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
